// File: rtl/gpt_top.sv
// General-purpose timer: prescaled up-counter with trigger slave modes and
// per-channel compare (PWM) or input-capture units.
`timescale 1ns / 1ps
module gpt_top #(
    parameter int unsigned CH_PAIRS_NUM = 2,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned PSC          = 0,
    parameter int unsigned ARR          = 99,
    parameter int unsigned TRG_SEL      = 1,
    parameter int unsigned SLAVE_MODE   = 1,
    parameter logic [2*CH_PAIRS_NUM-1:0]       CH_MODE  = '0,
    parameter logic [2*CH_PAIRS_NUM*CNT_W-1:0] CCR_INIT = '0
) (
    input  logic                      aclk_i,
    input  logic                      aresetn_i,
    input  logic [3:0]                itr_i,
    input  logic                      etr_i,
    input  logic [2*CH_PAIRS_NUM-1:0] ch_i,
    output logic                      trg_o,
    output logic [2*CH_PAIRS_NUM-1:0] ch_o
);
    localparam int unsigned N     = 2 * CH_PAIRS_NUM;
    localparam int unsigned SW    = 5 + N;
    localparam int unsigned PSC_W = (PSC > 0) ? $clog2(PSC + 1) : 1;
    localparam logic [4:0]  TRG_MASK = (TRG_SEL < 5) ? 5'(1 << TRG_SEL) : 5'd0;
    localparam logic        EN_RST   = (SLAVE_MODE != 1);

    logic [SW-1:0] sync1_q, sync2_q, sync3_q, rise;
    logic [1:0]    prime_q;
    logic          primed, trg_rise;
    logic [N-1:0]  ch_rise;

    always_ff @(posedge aclk_i) begin
        if (aresetn_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
            prime_q <= '0;
        end else begin
            sync1_q <= {ch_i, etr_i, itr_i};
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            if (prime_q != 2'd3) prime_q <= prime_q + 2'd1;
        end
    end

    // Edges are only trusted once the third stage holds a real sample, so an
    // input already high when reset releases is not mistaken for a rising edge.
    assign primed   = (prime_q == 2'd3);
    assign rise     = sync2_q & ~sync3_q & {SW{primed}};
    assign trg_rise = |(rise[4:0] & TRG_MASK);
    assign ch_rise  = rise[SW-1:5];

    logic             en_q, en_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PSC_W-1:0] psc_q, psc_d;
    logic             trg_q, trg_d;
    logic             tick;

    assign tick = en_q && (psc_q == PSC_W'(PSC));

    always_comb begin
        en_d  = en_q;
        cnt_d = cnt_q;
        psc_d = psc_q;
        trg_d = 1'b0;
        if (SLAVE_MODE == 1 && trg_rise) en_d = 1'b1;
        if (SLAVE_MODE == 2 && trg_rise) begin
            cnt_d = '0;
            psc_d = '0;
            trg_d = 1'b1;
        end else if (en_q) begin
            if (tick) begin
                psc_d = '0;
                if (cnt_q == CNT_W'(ARR)) begin
                    cnt_d = '0;
                    trg_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                psc_d = psc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge aclk_i) begin
        if (aresetn_i) begin
            en_q  <= EN_RST;
            cnt_q <= '0;
            psc_q <= '0;
            trg_q <= 1'b0;
        end else begin
            en_q  <= en_d;
            cnt_q <= cnt_d;
            psc_q <= psc_d;
            trg_q <= trg_d;
        end
    end

    logic [N-1:0][CNT_W-1:0] ccr_q;
    logic [N-1:0]            ch_q;

    // Compare channels hold CCR_INIT forever; capture channels latch cnt on edges.
    always_ff @(posedge aclk_i) begin
        if (aresetn_i) begin
            for (int n = 0; n < N; n++) begin
                ccr_q[n] <= CH_MODE[n] ? '0 : CCR_INIT[n*CNT_W +: CNT_W];
            end
            ch_q <= '0;
        end else begin
            for (int n = 0; n < N; n++) begin
                if (CH_MODE[n]) begin
                    ch_q[n] <= ch_rise[n];
                    if (ch_rise[n]) ccr_q[n] <= cnt_q;
                end else begin
                    ch_q[n] <= (cnt_q < ccr_q[n]);
                end
            end
        end
    end

    assign trg_o = trg_q;
    assign ch_o  = ch_q;

endmodule

// File: tb/tb_gpt_top.sv
// Bench for gpt_top: three instances (start-on-trigger with PWM/capture,
// prescaled free-run, reset-on-trigger) against an arithmetic reference model.
`timescale 1ns / 1ps
module tb_gpt_top;
    logic aclk_i = 1'b0;
    always #5 aclk_i = ~aclk_i;

    logic       rst;
    logic [3:0] itr_a, itr_b, itr_c;
    logic       etr_a, etr_b, etr_c;
    logic [3:0] ch_rand, ch_b, ch_c, ch_a;
    logic       ch_cap;
    logic       trg_a, trg_b, trg_c;
    logic [3:0] cho_a, cho_b, cho_c;

    assign ch_a = {ch_rand[3:2], ch_cap, ch_rand[0]};

    gpt_top #(
        .CH_PAIRS_NUM(2), .CNT_W(16), .PSC(0), .ARR(99), .TRG_SEL(1), .SLAVE_MODE(1),
        .CH_MODE(4'b0010), .CCR_INIT({16'd200, 16'd0, 16'd0, 16'd25})
    ) u_a (
        .aclk_i(aclk_i), .aresetn_i(rst), .itr_i(itr_a), .etr_i(etr_a), .ch_i(ch_a),
        .trg_o(trg_a), .ch_o(cho_a)
    );

    gpt_top #(
        .PSC(3), .ARR(4), .SLAVE_MODE(0)
    ) u_b (
        .aclk_i(aclk_i), .aresetn_i(rst), .itr_i(itr_b), .etr_i(etr_b), .ch_i(ch_b),
        .trg_o(trg_b), .ch_o(cho_b)
    );

    gpt_top #(
        .PSC(0), .ARR(99), .TRG_SEL(4), .SLAVE_MODE(2)
    ) u_c (
        .aclk_i(aclk_i), .aresetn_i(rst), .itr_i(itr_c), .etr_i(etr_c), .ch_i(ch_c),
        .trg_o(trg_c), .ch_o(cho_c)
    );

    int checks = 0;
    int failures = 0;
    int t = -1;

    // Reference model state
    int   a_start;          // edge at which u_a becomes enabled, -1 = never
    int   c_ref, c_pend;    // u_c count origin and pending trigger-reset edge
    bit   c_ref_trg;
    logic samp [0:1023];    // ch_i[1] of u_a as seen at each clock edge
    int   cap_val;
    int   pwm_hi;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int cnt_a(input int k);
        if (a_start >= 0 && k >= a_start) return (k - a_start) % 100;
        return 0;
    endfunction

    function automatic int cnt_c(input int k);
        return (k - c_ref) % 100;
    endfunction

    task automatic check_all();
        logic cap;
        // u_a: start-on-trigger, PWM on ch0/2/3, capture on ch1
        check("a_cnt", 32'(u_a.cnt_q), 32'(cnt_a(t)));
        check("a_trg", 32'(trg_a), 32'(a_start >= 0 && t > a_start && (t - a_start) % 100 == 0));
        check("a_ch0", 32'(cho_a[0]), 32'(t >= 1 && cnt_a(t - 1) < 25));
        check("a_ch2", 32'(cho_a[2]), 32'd0);
        check("a_ch3", 32'(cho_a[3]), 32'(t >= 1));
        cap = (t >= 4) && samp[t-2] && !samp[t-3];
        if (cap) cap_val = cnt_a(t - 1);
        check("a_ch1", 32'(cho_a[1]), 32'(cap));
        check("a_ccr1", 32'(u_a.ccr_q[1]), 32'(cap_val));
        // u_b: free-run, one count per 4 clocks, ARR=4
        check("b_cnt", 32'(u_b.cnt_q), 32'((t / 4) % 5));
        check("b_trg", 32'(trg_b), 32'(t > 0 && t % 20 == 0));
        check("b_cho", 32'(cho_b), 32'd0);
        // u_c: reset-on-trigger from etr
        check("c_cnt", 32'(u_c.cnt_q), 32'(cnt_c(t)));
        check("c_trg", 32'(trg_c),
              32'((c_ref_trg && t == c_ref) || (t > c_ref && (t - c_ref) % 100 == 0)));
        check("c_cho", 32'(cho_c), 32'd0);
    endtask

    task automatic model_reset();
        a_start   = -1;
        c_ref     = 0;
        c_pend    = -1;
        c_ref_trg = 1'b0;
        cap_val   = 0;
        pwm_hi    = 0;
        for (int i = 0; i < 1024; i++) samp[i] = 1'b0;
        t = 0;
    endtask

    task automatic step();
        @(posedge aclk_i);
        t++;
        samp[t] = ch_cap;
        if (t == c_pend) begin
            c_ref     = t;
            c_ref_trg = 1'b1;
        end
        #1;
        check_all();
    endtask

    // Asynchronous capture stimulus, kept off the clock edges by a 0.3 ns offset
    initial begin
        ch_cap = 1'b0;
        wait (t == 30);
        #0.3;
        repeat (60) begin
            #($urandom_range(10, 3));
            ch_cap = ~ch_cap;
        end
        ch_cap = 1'b0;
    end

    initial begin
        rst = 1'b1;
        itr_a = '0; itr_b = '0; itr_c = '0;
        etr_a = 1'b0; etr_b = 1'b0; etr_c = 1'b0;
        ch_rand = '0; ch_b = '0; ch_c = '0;
        repeat (3) @(posedge aclk_i);
        #1;
        rst = 1'b0;
        model_reset();
        check_all();

        // Epoch 1: start trigger, PWM, capture, etr reset-on-trigger
        while (t < 300) begin
            if (t == 3) itr_a = 4'b0001;
            if (t == 10) begin
                itr_a   = 4'b0011;
                a_start = t + 3;
            end
            if (t == 40) begin
                etr_c  = 1'b1;
                c_pend = t + 3;
            end
            itr_b   = 4'($urandom);
            etr_b   = 1'($urandom);
            itr_c   = 4'($urandom);
            ch_rand = 4'($urandom);
            ch_b    = 4'($urandom);
            ch_c    = 4'($urandom);
            step();
            if (a_start >= 0 && t > a_start && t <= a_start + 100 && cho_a[0]) pwm_hi++;
        end
        check("a_pwm_duty", 32'(pwm_hi), 32'd25);
        check("c_cnt_at_abort", 32'(u_c.cnt_q), 32'd57);

        // Reset mid-count; triggers left high must not restart anything
        rst = 1'b1;
        @(posedge aclk_i);
        #1;
        rst = 1'b0;
        model_reset();
        check_all();
        while (t < 60) begin
            itr_b   = 4'($urandom);
            ch_rand = 4'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gpt_top.md
GPT_TOP -- requirements
Module: gpt_top

Interface
REQ-001 Parameter CH_PAIRS_NUM, default 2, number of channel pairs; channel count N = 2*CH_PAIRS_NUM.
REQ-002 Parameter CNT_W, default 16, counter and capture/compare width.
REQ-003 Parameter PSC, default 0, prescaler; the counter advances once every PSC+1 clocks.
REQ-004 Parameter ARR, default 99, auto-reload value; the counter counts 0..ARR.
REQ-005 Parameter TRG_SEL, default 1, trigger source select: 0..3 = itr_i[TRG_SEL], 4 = etr_i, other values = constant 0.
REQ-006 Parameter SLAVE_MODE, default 1, trigger mode: 0 free-run, 1 start-on-trigger, 2 reset-on-trigger.
REQ-007 Parameter CH_MODE, N bits, default all 0, per-channel mode: 0 compare/PWM, 1 input capture.
REQ-008 Parameter CCR_INIT, N*CNT_W bits, default all 0, per-channel initial compare value.
REQ-009 aclk_i  input  1  single clock; all logic on its rising edge.
REQ-010 aresetn_i  input  1  reset; synchronous and active-high (1 = reset).
REQ-011 itr_i  input  4  internal trigger inputs; asynchronous.
REQ-012 etr_i  input  1  external trigger input; asynchronous.
REQ-013 ch_i  input  N  channel inputs; asynchronous.
REQ-014 trg_o  output  1  update-event pulse.
REQ-015 ch_o  output  N  channel outputs.

Function
REQ-016 itr_i, etr_i and ch_i each pass through a 2-flop synchronizer; an edge detector compares the second stage against a third delayed stage. A level sampled at edge K is acted on at edge K+2.
REQ-017 Prescaler counter psc_cnt counts 0..PSC and wraps; tick = enabled && psc_cnt==PSC.
REQ-018 On tick: if cnt==ARR, cnt <= 0 and trg_o is 1 for exactly the next cycle (update event); otherwise cnt <= cnt+1.
REQ-019 SLAVE_MODE 0: the counter is enabled immediately after reset.
REQ-020 SLAVE_MODE 1: the counter stays disabled at 0 until the first synchronized rising edge of the selected trigger, then stays enabled until reset. A trigger that is constantly high after reset produces no edge and does not start the counter.
REQ-021 SLAVE_MODE 2: the counter is enabled after reset. A trigger rising edge clears cnt and psc_cnt to 0 and pulses trg_o; this takes priority over a simultaneous tick.
REQ-022 Compare channel n (CH_MODE[n]=0): ccr[n]=CCR_INIT[n] (constant) and ch_o[n] <= (cnt < ccr[n]), registered one cycle behind cnt. ccr=0 gives a constant 0; ccr>ARR gives a constant 1.
REQ-023 Capture channel n (CH_MODE[n]=1): on a synchronized rising edge of ch_i[n], ccr[n] <= current cnt and ch_o[n] is 1 for one cycle; otherwise ch_o[n]=0. Capture works whether or not the counter is enabled.
REQ-024 Back-to-back edges shorter than the synchronizer resolution may merge; each detected edge captures independently, and the last capture wins.
REQ-025 Unsigned arithmetic; cnt never exceeds ARR; ARR=0 gives an update event every tick.

Reset
REQ-026 With aresetn_i=1 at a rising edge: cnt=0, psc_cnt=0, enable=(SLAVE_MODE!=1), synchronizer and edge flops=0, capture ccr=0, compare ccr=CCR_INIT, trg_o=0, ch_o=0.
REQ-027 Reset asserted mid-count aborts immediately. No trg_o pulse is produced by reset itself, and counting resumes per REQ-019..021 after release.

Verification
REQ-028 Start: SLAVE_MODE=1, TRG_SEL=1, PSC=0, ARR=99; itr_i goes 0000->0010 after reset -> cnt starts 2 edges after sampling. trg_o pulses once per 100 clocks thereafter.
REQ-029 Prescale: PSC=3, ARR=4, SLAVE_MODE=0 -> cnt increments every 4 clocks; trg_o period is 20 clocks, each pulse 1 cycle wide.
REQ-030 PWM: CH_MODE=0, CCR_INIT[0]=25, ARR=99 -> ch_o[0] high for 25 of every 100 clocks. CCR_INIT=0 gives ch_o constant 0; CCR_INIT=200 gives ch_o constant 1.
REQ-031 Capture: CH_MODE[1]=1; ch_i[1] toggles asynchronously with random 3..10 ns spacing (10 ns clock) -> each detected rising edge yields a 1-cycle ch_o[1] pulse, and ccr[1] equals cnt at the detection edge.
REQ-032 Reset-on-trigger: SLAVE_MODE=2, TRG_SEL=4; etr_i rises at cnt=40 -> cnt returns to 0 two edges later and trg_o pulses once.
REQ-033 Reset mid-count: assert aresetn_i=1 at cnt=57 -> next cycle cnt=0, ch_o=0, trg_o=0.
